// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a synchronous instruction memory
// and hands instructions to the decoder over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// FETCH   | issue a read for pc (imem_en/imem_addr registered this edge)
// WAIT    | read data on imem_rdata; capture it into the instruction register
// HOLD    | instruction presented to the decoder, waiting for instr_ready
// HALTED  | HALT consumed; idle until a redirect or reset
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 5,
  parameter int unsigned           INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'b1111
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_en,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic                   halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e                   state_q;
  logic [ADDR_WIDTH-1:0]    pc_q;
  logic [ADDR_WIDTH-1:0]    pc_d;
  logic [INSTR_WIDTH-1:0]   instr_q;
  logic [ADDR_WIDTH-1:0]    instr_pc_q;
  logic                     instr_valid_q;
  logic                     halt_pend_q;
  logic                     halted_q;
  logic                     imem_en_q;
  logic [ADDR_WIDTH-1:0]    imem_addr_q;
  logic                     handshake;
  logic                     is_halt;

  assign pc_d      = pc_q + ADDR_WIDTH'(1);
  assign handshake = instr_valid_q & instr_ready;
  assign is_halt   = (imem_rdata[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halt_pend_q   <= 1'b0;
      halted_q      <= 1'b0;
      imem_en_q     <= 1'b0;
      imem_addr_q   <= '0;
    end else if (redirect) begin
      // A handshake in this cycle still completes; only the next PC changes.
      state_q       <= S_FETCH;
      pc_q          <= redirect_target;
      instr_valid_q <= 1'b0;
      halt_pend_q   <= 1'b0;
      halted_q      <= 1'b0;
      imem_en_q     <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          imem_en_q   <= 1'b1;
          imem_addr_q <= pc_q;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          instr_q       <= imem_rdata;
          instr_pc_q    <= pc_q;
          pc_q          <= pc_d;
          instr_valid_q <= 1'b1;
          imem_en_q     <= 1'b0;
          halt_pend_q   <= is_halt;
          state_q       <= S_HOLD;
        end
        S_HOLD: begin
          if (handshake) begin
            instr_valid_q <= 1'b0;
            if (halt_pend_q) begin
              halted_q  <= 1'b1;
              imem_en_q <= 1'b0;
              state_q   <= S_HALTED;
            end else begin
              imem_en_q   <= 1'b1;
              imem_addr_q <= pc_q;
              state_q     <= S_WAIT;
            end
          end
        end
        S_HALTED: begin
          imem_en_q     <= 1'b0;
          instr_valid_q <= 1'b0;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_en     = imem_en_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a transaction-level model predicts the
// delivered (pc, word) stream and valid/halted timing; a monitor checks it.
module tb_instr_fetch_unit;

  localparam int AW = 5;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instruction;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_target;
  logic          halted;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .instruction     (instruction),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  // Memory whose read-address register is the DUT's registered imem_addr.
  logic [IW-1:0] mem [32];
  assign imem_rdata = imem_en ? mem[imem_addr] : 16'hE0E0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] ins;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: edges until the next instruction is presented.
  int            m_wait;
  logic          m_valid = 1'b0;
  logic          m_halted = 1'b0;
  logic          m_cur_halt;
  logic [AW-1:0] m_pc;

  logic started = 1'b0;
  logic done = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic model_edge(input logic rst, input logic rdy, input logic rd,
                            input logic [AW-1:0] tgt);
    logic [IW-1:0] w;
    if (rst) begin
      if (m_valid) void'(exp_q.pop_back());
      m_pc = '0; m_valid = 1'b0; m_halted = 1'b0; m_cur_halt = 1'b0; m_wait = 2;
    end else if (rd) begin
      if (m_valid && !rdy) void'(exp_q.pop_back());
      m_pc = tgt; m_valid = 1'b0; m_halted = 1'b0; m_cur_halt = 1'b0; m_wait = 2;
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        if (m_cur_halt) begin
          m_halted = 1'b1; m_wait = -1;
        end else begin
          m_wait = 1;
        end
      end
    end else if (m_wait > 0) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        w = mem[m_pc];
        exp_q.push_back('{pc: m_pc, ins: w});
        m_cur_halt = (w[15:12] == 4'hF);
        m_valid = 1'b1;
        m_pc = m_pc + 5'd1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic rd,
                      input logic [AW-1:0] tgt);
    reset = rst; instr_ready = rdy; redirect = rd; redirect_target = tgt;
    @(posedge clk);
    model_edge(rst, rdy, rd, tgt);
    #1;
  endtask

  exp_t e;

  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if (instr_valid !== m_valid) begin
        n_err++;
        $display("FAIL valid t=%0t got=%0b want=%0b", $time, instr_valid, m_valid);
      end
      n_cmp++;
      if (halted !== m_halted) begin
        n_err++;
        $display("FAIL halted t=%0t got=%0b want=%0b", $time, halted, m_halted);
      end
      if (m_valid || m_halted) begin
        n_cmp++;
        if (imem_en !== 1'b0) begin
          n_err++;
          $display("FAIL imem_en_idle t=%0t got=%0b want=0", $time, imem_en);
        end
      end
      if (!reset && instr_valid && instr_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_instr t=%0t got pc=%0d ins=%h want none",
                   $time, instr_pc, instruction);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e.pc || instruction !== e.ins) begin
            n_err++;
            $display("FAIL instr t=%0t got pc=%0d ins=%h want pc=%0d ins=%h",
                     $time, instr_pc, instruction, e.pc, e.ins);
          end
        end
      end
      if (done) begin
        n_cmp++;
        if (exp_q.size() != (m_valid ? 1 : 0)) begin
          n_err++;
          $display("FAIL leftover got=%0d want=%0d", exp_q.size(), m_valid ? 1 : 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    end
  end

  initial begin
    logic [IW-1:0] w;
    mem[0] = 16'b0001_0110_0110_0000;
    mem[1] = 16'b0101_0110_0110_0000;
    mem[2] = 16'hF000;
    for (int i = 3; i < 32; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 5) != 0) w[15:12] = 4'($urandom_range(0, 14));
      mem[i] = w;
    end
    mem[5] = 16'h3123;

    started = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 5'd0);
    // Straight run through the HALT word, then stay halted.
    repeat (16) step(1'b0, 1'b1, 1'b0, 5'd0);
    // Leave HALTED by redirect.
    step(1'b0, 1'b1, 1'b1, 5'd5);
    repeat (4) step(1'b0, 1'b1, 1'b0, 5'd0);
    // Backpressure while presented.
    step(1'b0, 1'b0, 1'b1, 5'd0);
    repeat (7) step(1'b0, 1'b0, 1'b0, 5'd0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 5'd0);
    // Redirect while a read is in flight.
    step(1'b0, 1'b1, 1'b1, 5'd1);
    repeat (4) step(1'b0, 1'b1, 1'b0, 5'd0);
    // Redirect coincident with a handshake.
    repeat (3) step(1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b1, 5'd3);
    repeat (4) step(1'b0, 1'b1, 1'b0, 5'd0);
    // PC wrap 31 -> 0.
    step(1'b0, 1'b1, 1'b1, 5'd31);
    repeat (8) step(1'b0, 1'b1, 1'b0, 5'd0);
    // Reset while holding an instruction.
    step(1'b0, 1'b0, 1'b1, 5'd10);
    repeat (4) step(1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 5'd0);
    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, 5'($urandom_range(0, 31)));
    end
    done = 1'b1;
    #100;
    $display("FAIL watchdog: summary not reached");
    $fatal(1);
  end

endmodule
